downconverter_nlane: RTL



---
 rtl/downconverter_nlane.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/downconverter_nlane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | downconverter_nlane                                                      |
// | LANES-wide complex mixer against an NCO (phase accumulator + full-cycle   |
// | sine/cosine ROM); down-convert, up-convert or bypass, round and saturate. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module downconverter_nlane #(
    parameter int WIDTH       = 16,
    parameter int LANES       = 2,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_ADDR    = 10,
    parameter int COEF_WIDTH  = 18
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [LANES*WIDTH-1:0]   i_inph_data,
    input  logic [LANES*WIDTH-1:0]   i_quad_data,
    input  logic                     i_valid,
    input  logic [1:0]               i_mode,
    input  logic [PHASE_WIDTH-1:0]   i_phase_inc,
    input  logic                     i_phase_inc_valid,
    input  logic                     i_phase_clear,
    output logic [LANES*WIDTH-1:0]   o_inph_data,
    output logic [LANES*WIDTH-1:0]   o_quad_data,
    output logic                     o_valid,
    output logic                     o_sat
);

    localparam int  c_DEPTH  = 1 << LUT_ADDR;
    localparam int  c_PROD_W = WIDTH + COEF_WIDTH;
    localparam int  c_SUM_W  = c_PROD_W + 1;
    localparam int  c_SHIFT  = COEF_WIDTH - 1;
    localparam real c_AMP    = real'((2 ** (COEF_WIDTH - 1)) - 1);
    localparam real c_TWO_PI = 6.283185307179586;

    localparam logic [1:0] c_MODE_UP = 2'd1;

    localparam logic signed [c_SUM_W-1:0] c_HALF =
        {{(c_SUM_W-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
    localparam logic signed [c_SUM_W-1:0] c_MAX =
        {{(c_SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_MIN =
        {{(c_SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [COEF_WIDTH-1:0] f_coef(input int n, input logic is_sin);
        real ang;
        real val;
        ang = c_TWO_PI * real'(n) / real'(c_DEPTH);
        val = c_AMP * (is_sin ? $sin(ang) : $cos(ang));
        return COEF_WIDTH'($rtoi(val >= 0.0 ? val + 0.5 : val - 0.5));
    endfunction

    logic signed [COEF_WIDTH-1:0] w_cos_rom [c_DEPTH];
    logic signed [COEF_WIDTH-1:0] w_sin_rom [c_DEPTH];

    for (genvar n = 0; n < c_DEPTH; n++) begin : g_rom
        assign w_cos_rom[n] = f_coef(n, 1'b0);
        assign w_sin_rom[n] = f_coef(n, 1'b1);
    end

    // Phase accumulator and increment
    logic [PHASE_WIDTH-1:0] r_acc;
    logic [PHASE_WIDTH-1:0] r_inc;
    logic [PHASE_WIDTH-1:0] w_acc_step;
    logic [PHASE_WIDTH-1:0] w_base;

    assign w_acc_step = PHASE_WIDTH'(LANES) * r_inc;
    assign w_base     = i_phase_clear ? '0 : r_acc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc <= '0;
            r_inc <= '0;
        end else begin
            if (i_phase_inc_valid) begin
                r_inc <= i_phase_inc;
            end
            if (i_phase_clear) begin
                r_acc <= i_valid ? w_acc_step : '0;
            end else if (i_valid) begin
                r_acc <= r_acc + w_acc_step;
            end
        end
    end

    logic signed [WIDTH-1:0] w_in_xi [LANES];
    logic signed [WIDTH-1:0] w_in_xq [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane_in
        assign w_in_xi[k] = i_inph_data[k*WIDTH +: WIDTH];
        assign w_in_xq[k] = i_quad_data[k*WIDTH +: WIDTH];
    end

    logic [3:0]                   r_vld;
    logic [1:0]                   r_s0_mode;
    logic [1:0]                   r_s1_mode;
    logic [1:0]                   r_s2_mode;
    logic [LUT_ADDR-1:0]          r_s0_addr [LANES];
    logic signed [WIDTH-1:0]      r_s0_xi   [LANES];
    logic signed [WIDTH-1:0]      r_s0_xq   [LANES];
    logic signed [WIDTH-1:0]      r_s1_xi   [LANES];
    logic signed [WIDTH-1:0]      r_s1_xq   [LANES];
    logic signed [COEF_WIDTH-1:0] r_s1_cos  [LANES];
    logic signed [COEF_WIDTH-1:0] r_s1_sin  [LANES];
    logic signed [WIDTH-1:0]      r_s2_xi   [LANES];
    logic signed [WIDTH-1:0]      r_s2_xq   [LANES];
    logic signed [c_PROD_W-1:0]   r_s2_ic   [LANES];
    logic signed [c_PROD_W-1:0]   r_s2_is   [LANES];
    logic signed [c_PROD_W-1:0]   r_s2_qc   [LANES];
    logic signed [c_PROD_W-1:0]   r_s2_qs   [LANES];
    logic signed [c_SUM_W-1:0]    r_s3_i    [LANES];
    logic signed [c_SUM_W-1:0]    r_s3_q    [LANES];

    // Data path carries no reset; only the valid chain and outputs are cleared.
    always_ff @(posedge i_clock) begin
        r_s0_mode <= i_mode;
        r_s1_mode <= r_s0_mode;
        r_s2_mode <= r_s1_mode;
        for (int k = 0; k < LANES; k++) begin
            r_s0_xi[k]   <= w_in_xi[k];
            r_s0_xq[k]   <= w_in_xq[k];
            r_s0_addr[k] <= LUT_ADDR'((w_base + PHASE_WIDTH'(k) * r_inc) >> (PHASE_WIDTH - LUT_ADDR));

            r_s1_xi[k]  <= r_s0_xi[k];
            r_s1_xq[k]  <= r_s0_xq[k];
            r_s1_cos[k] <= w_cos_rom[r_s0_addr[k]];
            r_s1_sin[k] <= w_sin_rom[r_s0_addr[k]];

            r_s2_xi[k] <= r_s1_xi[k];
            r_s2_xq[k] <= r_s1_xq[k];
            r_s2_ic[k] <= c_PROD_W'(r_s1_xi[k]) * c_PROD_W'(r_s1_cos[k]);
            r_s2_is[k] <= c_PROD_W'(r_s1_xi[k]) * c_PROD_W'(r_s1_sin[k]);
            r_s2_qc[k] <= c_PROD_W'(r_s1_xq[k]) * c_PROD_W'(r_s1_cos[k]);
            r_s2_qs[k] <= c_PROD_W'(r_s1_xq[k]) * c_PROD_W'(r_s1_sin[k]);

            // Bypass is pre-scaled so the shared rounding stage returns the sample exactly.
            if (r_s2_mode[1]) begin
                r_s3_i[k] <= c_SUM_W'(r_s2_xi[k]) <<< c_SHIFT;
                r_s3_q[k] <= c_SUM_W'(r_s2_xq[k]) <<< c_SHIFT;
            end else if (r_s2_mode == c_MODE_UP) begin
                r_s3_i[k] <= c_SUM_W'(r_s2_ic[k]) - c_SUM_W'(r_s2_qs[k]);
                r_s3_q[k] <= c_SUM_W'(r_s2_qc[k]) + c_SUM_W'(r_s2_is[k]);
            end else begin
                r_s3_i[k] <= c_SUM_W'(r_s2_ic[k]) + c_SUM_W'(r_s2_qs[k]);
                r_s3_q[k] <= c_SUM_W'(r_s2_qc[k]) - c_SUM_W'(r_s2_is[k]);
            end
        end
    end

    logic signed [c_SUM_W-1:0] w_i_scaled [LANES];
    logic signed [c_SUM_W-1:0] w_q_scaled [LANES];
    logic [LANES-1:0]          w_i_hi;
    logic [LANES-1:0]          w_i_lo;
    logic [LANES-1:0]          w_q_hi;
    logic [LANES-1:0]          w_q_lo;
    logic [LANES-1:0]          w_lane_sat;
    logic [LANES*WIDTH-1:0]    w_out_i;
    logic [LANES*WIDTH-1:0]    w_out_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane_out
        assign w_i_scaled[k] = (r_s3_i[k] + c_HALF) >>> c_SHIFT;
        assign w_q_scaled[k] = (r_s3_q[k] + c_HALF) >>> c_SHIFT;
        assign w_i_hi[k]     = w_i_scaled[k] > c_MAX;
        assign w_i_lo[k]     = w_i_scaled[k] < c_MIN;
        assign w_q_hi[k]     = w_q_scaled[k] > c_MAX;
        assign w_q_lo[k]     = w_q_scaled[k] < c_MIN;
        assign w_lane_sat[k] = w_i_hi[k] | w_i_lo[k] | w_q_hi[k] | w_q_lo[k];
        assign w_out_i[k*WIDTH +: WIDTH] = w_i_hi[k] ? c_MAX[WIDTH-1:0] :
                                           w_i_lo[k] ? c_MIN[WIDTH-1:0] :
                                           w_i_scaled[k][WIDTH-1:0];
        assign w_out_q[k*WIDTH +: WIDTH] = w_q_hi[k] ? c_MAX[WIDTH-1:0] :
                                           w_q_lo[k] ? c_MIN[WIDTH-1:0] :
                                           w_q_scaled[k][WIDTH-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vld       <= '0;
            o_valid     <= 1'b0;
            o_sat       <= 1'b0;
            o_inph_data <= '0;
            o_quad_data <= '0;
        end else begin
            r_vld   <= {r_vld[2:0], i_valid};
            o_valid <= r_vld[3];
            if (r_vld[3]) begin
                o_inph_data <= w_out_i;
                o_quad_data <= w_out_q;
                o_sat       <= |w_lane_sat;
            end
        end
    end

endmodule
`default_nettype wire
